// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE X-operand prefetch scheduler.
// Config fields are held at a generous fixed width; each user slices
// them down to its own parameterised widths.
package redmule_pkg;

  localparam int unsigned XSCHED_MAX_OUTSTANDING = 2;

  localparam int unsigned XSCHED_CFG_ADDR_W = 64;
  localparam int unsigned XSCHED_CFG_ITER_W = 32;
  localparam int unsigned XSCHED_CFG_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } xsched_state_e;

  typedef struct packed {
    logic [XSCHED_CFG_ADDR_W-1:0] x_addr;
    logic [XSCHED_CFG_ITER_W-1:0] cols_iters;
    logic [XSCHED_CFG_ITER_W-1:0] w_iters;
    logic [XSCHED_CFG_ITER_W-1:0] rows_iters;
    logic [XSCHED_CFG_ADDR_W-1:0] rows_offs;
    logic [XSCHED_CFG_LEN_W-1:0]  rows_lftovr;
  } xsched_cfg_t;

endpackage

// File: rtl/redmule_loop_counter.sv
// One level of the X tile loop nest: an index counter that wraps at max_i
// plus a byte-offset accumulator that grows by step_i per advance and
// returns to zero on wrap. wrap_o feeds the enable of the next outer level.
module redmule_loop_counter #(
  parameter int unsigned IterW = 16,
  parameter int unsigned AddrW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_i,
  input  logic             en_i,
  input  logic [IterW-1:0] max_i,
  input  logic [AddrW-1:0] step_i,
  output logic [IterW-1:0] cnt_o,
  output logic [AddrW-1:0] offs_o,
  output logic             last_o,
  output logic             wrap_o
);

  logic [IterW-1:0] cnt_q, cnt_d;
  logic [AddrW-1:0] offs_q, offs_d;

  assign last_o = (cnt_q == max_i);
  assign wrap_o = en_i && last_o;
  assign cnt_o  = cnt_q;
  assign offs_o = offs_q;

  // Next index/offset: init beats advance; wrap returns both to zero.
  always_comb begin
    cnt_d  = cnt_q;
    offs_d = offs_q;
    if (init_i) begin
      cnt_d  = '0;
      offs_d = '0;
    end else if (en_i) begin
      if (last_o) begin
        cnt_d  = '0;
        offs_d = '0;
      end else begin
        cnt_d  = cnt_q + IterW'(1);
        offs_d = offs_q + step_i;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      offs_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      offs_q <= offs_d;
    end
  end

endmodule

// File: rtl/redmule_x_prefetch_scheduler.sv
// RedMulE X-operand prefetch scheduler: issues one (base, length) request
// per X tile over a col (inner) / W pass / row (outer) loop nest, keeps at
// most MaxOutstanding loads in flight, and pulses done_o once all loads
// have completed. Optional stall counter: REDMULE_XSCHED_PERF_EN.
module redmule_x_prefetch_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned W              = 12,
  parameter int unsigned AddrW          = 32,
  parameter int unsigned IterW          = 16,
  parameter int unsigned MaxOutstanding = XSCHED_MAX_OUTSTANDING,
  parameter int unsigned JmpBytes       = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [AddrW-1:0]   cfg_x_addr_i,
  input  logic [IterW-1:0]   cfg_cols_iters_i,
  input  logic [IterW-1:0]   cfg_w_iters_i,
  input  logic [IterW-1:0]   cfg_rows_iters_i,
  input  logic [AddrW-1:0]   cfg_rows_offs_i,
  input  logic [$clog2(W):0] cfg_rows_lftovr_i,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic [AddrW-1:0]   req_base_addr_o,
  output logic [$clog2(W):0] req_tot_len_o,
  input  logic               load_done_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [31:0]        stall_cycles_o
);

  localparam int unsigned LenW  = $clog2(W) + 1;
  localparam int unsigned InflW = $clog2(MaxOutstanding + 1);

  // A loop count of zero behaves as a single iteration.
  function automatic logic [IterW-1:0] iter_max(input logic [IterW-1:0] n);
    return (n == '0) ? '0 : n - IterW'(1);
  endfunction

  xsched_state_e    state_q, state_d;
  xsched_cfg_t      cfg_q, cfg_d;
  logic [InflW-1:0] inflight_q, inflight_d;
  logic             done_q, done_d;

  logic             start_go, cnt_init, accept, credit_ret;
  logic             col_last, col_wrap, w_last, w_wrap, row_last, row_wrap;
  logic [IterW-1:0] col_cnt, w_cnt, row_cnt;
  logic [AddrW-1:0] col_offs, w_offs, row_offs;
  logic [LenW-1:0]  lftovr;

  // Config bits above the parameterised widths, and the per-level indices,
  // are intentionally unobserved.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_q, col_cnt, w_cnt, row_cnt, w_offs, row_wrap};

  assign start_go    = (state_q == IDLE) && start_i;
  assign cnt_init    = clear_i || start_go;
  assign req_valid_o = (state_q == ISSUE) && (inflight_q < InflW'(MaxOutstanding));
  assign accept      = req_valid_o && req_ready_i;
  assign credit_ret  = load_done_i && (inflight_q != '0);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign lftovr      = cfg_q.rows_lftovr[LenW-1:0];

  assign req_base_addr_o = cfg_q.x_addr[AddrW-1:0] + row_offs + col_offs;
  assign req_tot_len_o   = ((state_q == ISSUE) && row_last && (lftovr != '0)) ? lftovr : LenW'(W);

  redmule_loop_counter #(.IterW(IterW), .AddrW(AddrW)) i_col_cnt (
    .clk_i, .rst_ni, .init_i(cnt_init), .en_i(accept),
    .max_i(iter_max(cfg_q.cols_iters[IterW-1:0])), .step_i(AddrW'(JmpBytes)),
    .cnt_o(col_cnt), .offs_o(col_offs), .last_o(col_last), .wrap_o(col_wrap)
  );

  redmule_loop_counter #(.IterW(IterW), .AddrW(AddrW)) i_w_cnt (
    .clk_i, .rst_ni, .init_i(cnt_init), .en_i(col_wrap),
    .max_i(iter_max(cfg_q.w_iters[IterW-1:0])), .step_i('0),
    .cnt_o(w_cnt), .offs_o(w_offs), .last_o(w_last), .wrap_o(w_wrap)
  );

  redmule_loop_counter #(.IterW(IterW), .AddrW(AddrW)) i_row_cnt (
    .clk_i, .rst_ni, .init_i(cnt_init), .en_i(w_wrap),
    .max_i(iter_max(cfg_q.rows_iters[IterW-1:0])), .step_i(cfg_q.rows_offs[AddrW-1:0]),
    .cnt_o(row_cnt), .offs_o(row_offs), .last_o(row_last), .wrap_o(row_wrap)
  );

  // Config capture on start; clear wipes it so the address output returns to 0.
  always_comb begin
    cfg_d = cfg_q;
    if (clear_i) begin
      cfg_d = '0;
    end else if (start_go) begin
      cfg_d.x_addr      = XSCHED_CFG_ADDR_W'(cfg_x_addr_i);
      cfg_d.cols_iters  = XSCHED_CFG_ITER_W'(cfg_cols_iters_i);
      cfg_d.w_iters     = XSCHED_CFG_ITER_W'(cfg_w_iters_i);
      cfg_d.rows_iters  = XSCHED_CFG_ITER_W'(cfg_rows_iters_i);
      cfg_d.rows_offs   = XSCHED_CFG_ADDR_W'(cfg_rows_offs_i);
      cfg_d.rows_lftovr = XSCHED_CFG_LEN_W'(cfg_rows_lftovr_i);
    end
  end

  // Next state, done pulse and credit tracking; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    inflight_d = inflight_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE:   if (accept && col_last && w_last && row_last) state_d = DRAIN;
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && !credit_ret) inflight_d = inflight_q + InflW'(1);
    else if (!accept && credit_ret) inflight_d = inflight_q - InflW'(1);
    if (clear_i) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      inflight_d = '0;
    end
  end

  // Control and config registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

`ifdef REDMULE_XSCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of ISSUE cycles that did not hand off a request.
  always_comb begin
    stall_d = stall_q;
    if (clear_i || start_i) stall_d = '0;
    else if ((state_q == ISSUE) && !accept && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_redmule_x_prefetch_scheduler.sv
// Directed bench for redmule_x_prefetch_scheduler (default parameters).
module tb_redmule_x_prefetch_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i, start_i;
  logic [31:0] cfg_x_addr_i, cfg_rows_offs_i;
  logic [15:0] cfg_cols_iters_i, cfg_w_iters_i, cfg_rows_iters_i;
  logic [4:0]  cfg_rows_lftovr_i;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_base_addr_o;
  logic [4:0]  req_tot_len_o;
  logic        load_done_i, busy_o, done_o;
  logic [31:0] stall_cycles_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] acc_addr[8];
  logic [4:0]  acc_len[8];
  int          n_acc;
  int          n_done;

`ifdef REDMULE_XSCHED_PERF_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  redmule_x_prefetch_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .cfg_x_addr_i(cfg_x_addr_i), .cfg_cols_iters_i(cfg_cols_iters_i),
    .cfg_w_iters_i(cfg_w_iters_i), .cfg_rows_iters_i(cfg_rows_iters_i),
    .cfg_rows_offs_i(cfg_rows_offs_i), .cfg_rows_lftovr_i(cfg_rows_lftovr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_base_addr_o(req_base_addr_o), .req_tot_len_o(req_tot_len_o),
    .load_done_i(load_done_i), .busy_o(busy_o), .done_o(done_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Latch a config, then scramble the cfg inputs to prove they were captured.
  task automatic do_start(input logic [31:0] a, input logic [15:0] c, input logic [15:0] w,
                          input logic [15:0] r, input logic [31:0] o, input logic [4:0] l);
    cfg_x_addr_i = a; cfg_cols_iters_i = c; cfg_w_iters_i = w;
    cfg_rows_iters_i = r; cfg_rows_offs_i = o; cfg_rows_lftovr_i = l;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cfg_x_addr_i = 32'hDEAD_BEE0; cfg_cols_iters_i = 16'd9; cfg_w_iters_i = 16'd9;
    cfg_rows_iters_i = 16'd9; cfg_rows_offs_i = 32'h0BAD_0000; cfg_rows_lftovr_i = 5'd3;
  endtask

  // Run n cycles, logging each handshake and each done pulse.
  task automatic run_log(input int n);
    for (int i = 0; i < n; i++) begin
      if (req_valid_o && req_ready_i && n_acc < 8) begin
        acc_addr[n_acc] = req_base_addr_o;
        acc_len[n_acc]  = req_tot_len_o;
        n_acc++;
      end
      if (done_o) n_done++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; req_ready_i = 1'b0; load_done_i = 1'b0;
    cfg_x_addr_i = '0; cfg_cols_iters_i = '0; cfg_w_iters_i = '0; cfg_rows_iters_i = '0;
    cfg_rows_offs_i = '0; cfg_rows_lftovr_i = '0;
    tick(); tick();
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", req_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (req_base_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", req_base_addr_o); end
    checks++; if (req_tot_len_o !== 5'd12) begin failures++; $display("FAIL rst_len got=%0d exp=12", req_tot_len_o); end
    checks++; if (stall_cycles_o !== 32'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles_o); end
    rst_ni = 1'b1;
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_basic();
    req_ready_i = 1'b1;
    do_start(32'h1000, 16'd2, 16'd1, 16'd1, 32'h0, 5'd0);
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid0 got=%b exp=1", req_valid_o); end
    checks++; if (req_base_addr_o !== 32'h1000) begin failures++; $display("FAIL basic_addr0 got=%h exp=1000", req_base_addr_o); end
    checks++; if (req_tot_len_o !== 5'd12) begin failures++; $display("FAIL basic_len0 got=%0d exp=12", req_tot_len_o); end
    tick();
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid1 got=%b exp=1", req_valid_o); end
    checks++; if (req_base_addr_o !== 32'h1020) begin failures++; $display("FAIL basic_addr1 got=%h exp=1020", req_base_addr_o); end
    tick();
    req_ready_i = 1'b0;
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL basic_drain_valid got=%b exp=0", req_valid_o); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_drain_busy got=%b exp=1", busy_o); end
    load_done_i = 1'b1; tick(); tick(); load_done_i = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_o) begin
        n_done++;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_o); end
      end
      tick();
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy_o); end
  endtask

  task automatic test_wpass_rows();
    logic [31:0] ea[4];
    logic [4:0]  el[4];
    ea[0] = 32'h0; ea[1] = 32'h0; ea[2] = 32'h180; ea[3] = 32'h180;
    el[0] = 5'd12; el[1] = 5'd12; el[2] = 5'd5; el[3] = 5'd5;
    req_ready_i = 1'b1; load_done_i = 1'b1;
    do_start(32'h0, 16'd1, 16'd2, 16'd2, 32'h180, 5'd5);
    n_acc = 0; n_done = 0;
    run_log(20);
    req_ready_i = 1'b0; load_done_i = 1'b0;
    checks++; if (n_acc != 4) begin failures++; $display("FAIL wrows_count got=%0d exp=4", n_acc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc_addr[i] !== ea[i]) begin failures++; $display("FAIL wrows_addr%0d got=%h exp=%h", i, acc_addr[i], ea[i]); end
      checks++; if (acc_len[i] !== el[i]) begin failures++; $display("FAIL wrows_len%0d got=%0d exp=%0d", i, acc_len[i], el[i]); end
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL wrows_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_credits();
    req_ready_i = 1'b1;
    do_start(32'h2000, 16'd4, 16'd1, 16'd1, 32'h0, 5'd0);
    n_acc = 0; n_done = 0;
    run_log(6);
    checks++; if (n_acc != 2) begin failures++; $display("FAIL cred_accepts got=%0d exp=2", n_acc); end
    checks++; if (acc_addr[1] !== 32'h2020) begin failures++; $display("FAIL cred_addr1 got=%h exp=2020", acc_addr[1]); end
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL cred_valid_full got=%b exp=0", req_valid_o); end
    load_done_i = 1'b1; tick(); load_done_i = 1'b0;
    n_acc = 0;
    run_log(6);
    checks++; if (n_acc != 1) begin failures++; $display("FAIL cred_refill got=%0d exp=1", n_acc); end
    checks++; if (acc_addr[0] !== 32'h2040) begin failures++; $display("FAIL cred_addr2 got=%h exp=2040", acc_addr[0]); end
    req_ready_i = 1'b0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  task automatic test_stall();
    req_ready_i = 1'b0;
    do_start(32'h3000, 16'd1, 16'd1, 16'd1, 32'h0, 5'd7);
    checks++; if (req_base_addr_o !== 32'h3000) begin failures++; $display("FAIL stall_addr0 got=%h exp=3000", req_base_addr_o); end
    checks++; if (req_tot_len_o !== 5'd7) begin failures++; $display("FAIL stall_len0 got=%0d exp=7", req_tot_len_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid%0d got=%b exp=1", k, req_valid_o); end
      checks++; if (req_base_addr_o !== 32'h3000) begin failures++; $display("FAIL stall_addr%0d got=%h exp=3000", k, req_base_addr_o); end
      checks++; if (req_tot_len_o !== 5'd7) begin failures++; $display("FAIL stall_len%0d got=%0d exp=7", k, req_tot_len_o); end
    end
    checks++; if (stall_cycles_o !== EXP_STALL) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", stall_cycles_o, EXP_STALL); end
    req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
    load_done_i = 1'b1; tick(); load_done_i = 1'b0;
    n_acc = 0; n_done = 0;
    run_log(8);
    checks++; if (n_done != 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", n_done); end
    checks++; if (stall_cycles_o !== EXP_STALL) begin failures++; $display("FAIL stall_hold got=%0d exp=%0d", stall_cycles_o, EXP_STALL); end
  endtask

  task automatic test_clear();
    req_ready_i = 1'b1;
    do_start(32'h4000, 16'd2, 16'd1, 16'd1, 32'h0, 5'd0);
    tick();
    req_ready_i = 1'b0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy_o); end
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", req_valid_o); end
    checks++; if (req_base_addr_o !== 32'h0) begin failures++; $display("FAIL clr_addr got=%h exp=0", req_base_addr_o); end
    n_acc = 0; n_done = 0;
    run_log(5);
    checks++; if (n_done != 0) begin failures++; $display("FAIL clr_no_done got=%0d exp=0", n_done); end
    req_ready_i = 1'b1;
    do_start(32'h4000, 16'd3, 16'd1, 16'd1, 32'h0, 5'd0);
    n_acc = 0;
    run_log(6);
    checks++; if (n_acc != 2) begin failures++; $display("FAIL clr_restart_accepts got=%0d exp=2", n_acc); end
    checks++; if (acc_addr[0] !== 32'h4000) begin failures++; $display("FAIL clr_restart_addr got=%h exp=4000", acc_addr[0]); end
    req_ready_i = 1'b0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  task automatic test_same_cycle();
    load_done_i = 1'b1; tick(); tick(); load_done_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL spur_done got=%b exp=0", done_o); end
    req_ready_i = 1'b1;
    do_start(32'h5000, 16'd4, 16'd1, 16'd1, 32'h0, 5'd0);
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL same_valid_start got=%b exp=1", req_valid_o); end
    tick();
    load_done_i = 1'b1; tick(); load_done_i = 1'b0;
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL same_valid_mid got=%b exp=1", req_valid_o); end
    checks++; if (req_base_addr_o !== 32'h5040) begin failures++; $display("FAIL same_addr got=%h exp=5040", req_base_addr_o); end
    tick();
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL same_full got=%b exp=0", req_valid_o); end
    req_ready_i = 1'b0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wpass_rows();
    test_credits();
    test_stall();
    test_clear();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
